// File: rtl/uart_click_pkg.sv
// Shared definitions for the remote-click UART link (transmitter and receiver).
package uart_click_pkg;

  localparam logic [7:0] CLICK_BYTE = 8'hC1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } tx_state_t;

  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the last cycle of each bit.
// Latency: bit_done is combinational from the count register; restart zeroes it next cycle.
// No backpressure: free-running, restart may be asserted in any cycle.
module uart_bit_timer #(
  parameter int BIT_CYCLES = 564
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bit_done = (cnt_q == LAST);

endmodule

// File: rtl/uart_click_tx.sv
// Click-pulse to 8N1 UART frame transmitter with a saturating click queue.
// Latency: start bit appears one cycle after the click is counted; frames go back-to-back.
// No backpressure: clicks accepted every cycle, excess beyond MAX_PENDING dropped and flagged.
module uart_click_tx
  import uart_click_pkg::*;
#(
  parameter int CLK_FREQ    = 65_000_000,
  parameter int BAUD        = 115_200,
  parameter int GAP_BITS    = 2,
  parameter int MAX_PENDING = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       click_in,
  output logic       tx_out,
  output logic       busy,
  output logic [2:0] pending_cnt,
  output logic       dropped
);

  localparam int         BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam logic [2:0] MAX_CNT    = 3'(MAX_PENDING);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_BITS - 1);

  tx_state_t  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] gap_idx_q, gap_idx_d;
  logic       bit_done, frame_end, deq;
  logic       tx_d, busy_d, drop_d;
  logic [2:0] pend_d;

  uart_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (deq),
    .bit_done(bit_done)
  );

  // A queued click is dequeued either from IDLE or straight off the end of the
  // previous frame, so back-to-back frames leave no extra idle cycle.
  assign frame_end = bit_done &&
                     (((state_q == STOP) && (GAP_BITS == 0)) ||
                      ((state_q == GAP) && (gap_idx_q == GAP_LAST)));
  assign deq = (pending_cnt != 3'd0) && ((state_q == IDLE) || frame_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      gap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      gap_idx_q <= gap_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    gap_idx_d = gap_idx_q;
    case (state_q)
      IDLE: begin
        if (deq) state_d = START;
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (GAP_BITS == 0) begin
            state_d = deq ? START : IDLE;
          end else begin
            state_d   = GAP;
            gap_idx_d = '0;
          end
        end
      end
      GAP: begin
        if (frame_end) begin
          state_d = deq ? START : IDLE;
        end else if (bit_done) begin
          gap_idx_d = gap_idx_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = CLICK_BYTE[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // A click landing on the dequeue cycle replaces the dequeued entry one-for-one.
  always_comb begin
    pend_d = pending_cnt;
    drop_d = 1'b0;
    if (click_in && !deq) begin
      if (pending_cnt == MAX_CNT) drop_d = 1'b1;
      else                        pend_d = pending_cnt + 3'd1;
    end else if (!click_in && deq) begin
      pend_d = pending_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_out      <= 1'b1;
      busy        <= 1'b0;
      pending_cnt <= '0;
      dropped     <= 1'b0;
    end else begin
      tx_out      <= tx_d;
      busy        <= busy_d;
      pending_cnt <= pend_d;
      dropped     <= drop_d;
    end
  end

endmodule

// File: tb/tb_uart_click_tx.sv
// Bench for uart_click_tx at 10 cycles/bit: timing table, frame scoreboard, queue corner cases.
`timescale 1ns/1ps
module tb_uart_click_tx;

  localparam logic [7:0] EXP_BYTE = 8'hC1;

  typedef struct {
    int         n;
    logic       tx;
    logic       bsy;
    logic [2:0] pend;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       click_in = 1'b0;
  logic       tx_out, busy, dropped;
  logic [2:0] pending_cnt;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   frames = 0;
  int   max_pend = 0;
  int   drop_cnt = 0;
  bit   mon_en = 1'b0;
  bit   track_en = 1'b0;
  logic [7:0] exp_q[$];
  int   start_q[$];

  uart_click_tx #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .GAP_BITS   (2),
    .MAX_PENDING(7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .click_in   (click_in),
    .tx_out     (tx_out),
    .busy       (busy),
    .pending_cnt(pending_cnt),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (track_en) begin
      if (int'(pending_cnt) > max_pend) max_pend = int'(pending_cnt);
      if (dropped === 1'b1) drop_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic click(input bit expect_frame);
    click_in = 1'b1;
    if (expect_frame) exp_q.push_back(EXP_BYTE);
    step();
    click_in = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string nm);
    int b;
    b = budget;
    while (((frames < target) || (busy !== 1'b0)) && (b > 0)) begin
      step();
      b--;
    end
    chk(nm, frames, target);
    chk({nm, "_left"}, exp_q.size(), 0);
  endtask

  // Line receiver: samples each bit mid-period and checks bytes against the scoreboard.
  initial begin : monitor
    logic [7:0] b;
    logic       stop_b;
    forever begin
      @(posedge clk); #2;
      if (mon_en && rst && (tx_out === 1'b0)) begin
        start_q.push_back(cyc);
        repeat (4) begin @(posedge clk); #2; end
        chk("start_mid", tx_out, 0);
        for (int k = 0; k < 8; k++) begin
          repeat (10) begin @(posedge clk); #2; end
          b[k] = tx_out;
        end
        repeat (10) begin @(posedge clk); #2; end
        stop_b = tx_out;
        chk("stop_bit", stop_b, 1);
        frames++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got byte %02h, none expected (cycle %0d)", b, cyc);
        end else begin
          chk("frame_byte", b, exp_q.pop_front());
        end
        repeat (5) begin @(posedge clk); #2; end
      end
    end
  end

  initial begin : stim
    vec_t vt[16];
    int   rel;
    int   base;
    int   viol;

    vt[0]  = '{n:0,   tx:1'b1, bsy:1'b0, pend:3'd1};
    vt[1]  = '{n:1,   tx:1'b0, bsy:1'b1, pend:3'd0};
    vt[2]  = '{n:10,  tx:1'b0, bsy:1'b1, pend:3'd0};
    vt[3]  = '{n:11,  tx:1'b1, bsy:1'b1, pend:3'd0};
    vt[4]  = '{n:20,  tx:1'b1, bsy:1'b1, pend:3'd0};
    vt[5]  = '{n:21,  tx:1'b0, bsy:1'b1, pend:3'd0};
    vt[6]  = '{n:70,  tx:1'b0, bsy:1'b1, pend:3'd0};
    vt[7]  = '{n:71,  tx:1'b1, bsy:1'b1, pend:3'd0};
    vt[8]  = '{n:80,  tx:1'b1, bsy:1'b1, pend:3'd0};
    vt[9]  = '{n:81,  tx:1'b1, bsy:1'b1, pend:3'd0};
    vt[10] = '{n:90,  tx:1'b1, bsy:1'b1, pend:3'd0};
    vt[11] = '{n:91,  tx:1'b1, bsy:1'b1, pend:3'd0};
    vt[12] = '{n:100, tx:1'b1, bsy:1'b1, pend:3'd0};
    vt[13] = '{n:101, tx:1'b1, bsy:1'b1, pend:3'd0};
    vt[14] = '{n:120, tx:1'b1, bsy:1'b1, pend:3'd0};
    vt[15] = '{n:121, tx:1'b1, bsy:1'b0, pend:3'd0};

    // Reset
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pending_cnt, 0);
    chk("rst_drop", dropped, 0);
    mon_en = 1'b1;
    repeat (3) step();

    // Single click, checked against the timing table
    frames = 0;
    click(1'b1);
    rel = 0;
    for (int i = 0; i < 16; i++) begin
      while (rel < vt[i].n) begin
        step();
        rel++;
      end
      chk($sformatf("v%0d_tx", i), tx_out, vt[i].tx);
      chk($sformatf("v%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("v%0d_pend", i), pending_cnt, vt[i].pend);
    end
    wait_frames(1, 200, "single_frames");

    // Three clicks five cycles apart
    frames = 0;
    start_q.delete();
    max_pend = 0;
    track_en = 1'b1;
    click(1'b1);
    base = cyc;
    repeat (4) step();
    click(1'b1);
    repeat (4) step();
    click(1'b1);
    wait_frames(3, 600, "three_frames");
    track_en = 1'b0;
    chk("three_peak", max_pend, 2);
    chk("three_starts", start_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < start_q.size()) chk($sformatf("three_start%0d", i), start_q[i] - base, 1 + 120 * i);
    end

    // Nine clicks on consecutive cycles: 7 queued, 1 in flight, 1 dropped
    frames = 0;
    max_pend = 0;
    drop_cnt = 0;
    track_en = 1'b1;
    for (int i = 0; i < 9; i++) click(i < 8);
    wait_frames(8, 1300, "nine_frames");
    track_en = 1'b0;
    chk("nine_peak", max_pend, 7);
    chk("nine_drops", drop_cnt, 1);
    chk("nine_pend_end", pending_cnt, 0);

    // Click coincident with the dequeue while the queue is full
    frames = 0;
    drop_cnt = 0;
    track_en = 1'b1;
    click(1'b1);
    step();
    for (int i = 0; i < 7; i++) click(1'b1);
    rel = 8;
    while (rel < 120) begin
      step();
      rel++;
    end
    chk("coin_pre_pend", pending_cnt, 7);
    chk("coin_pre_busy", busy, 1);
    click(1'b1);
    chk("coin_pend", pending_cnt, 7);
    chk("coin_tx", tx_out, 0);
    chk("coin_drop0", dropped, 0);
    step();
    chk("coin_drop1", dropped, 0);
    wait_frames(9, 1300, "coin_frames");
    track_en = 1'b0;
    chk("coin_drops", drop_cnt, 0);

    // Asynchronous reset in the middle of the data bits
    mon_en = 1'b0;
    click(1'b0);
    repeat (4) step();
    click(1'b0);
    rel = 5;
    while (rel < 30) begin
      step();
      rel++;
    end
    chk("mid_pre_tx", tx_out, 0);
    chk("mid_pre_pend", pending_cnt, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", tx_out, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pend", pending_cnt, 0);
    repeat (3) step();
    rst = 1'b1;
    step();
    frames = 0;
    mon_en = 1'b1;

    // Long idle stretch: no resumed frame, line held high
    viol = 0;
    repeat (10000) begin
      step();
      if ((tx_out !== 1'b1) || (busy !== 1'b0)) viol++;
    end
    chk("idle_viol", viol, 0);
    chk("idle_frames", frames, 0);
    chk("idle_pend", pending_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
